// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Multicycle sequencer for the single-issue CPU datapath. Each instruction is
// stepped through FETCH, DECODE, EXEC, (MEM), WB. The block drives the
// datapath enables and selects and handshakes with instruction and data
// memory through req/ack pairs with a bounded wait.
//
// Handshake: a request output (imem_req_o / dmem_req_o) is held high for
// every cycle the FSM sits in the matching request state. A cycle in that
// state with the matching ack high completes the transfer. An ack seen in
// any other state is ignored. If no ack arrives within ACK_TIMEOUT request
// cycles, the FSM parks in ERROR until reset.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i               run enable (sampled in IDLE and at retire)
//   opcode_i [OPW]        decoder opcode (sampled in DECODE)
//   imem_ack_i            instruction memory ack
//   dmem_ack_i            data memory ack
//   imem_req_o, ir_en_o   fetch request, instruction register load
//   dmem_req_o, dmem_we_o data request, data write
//   alub_sel_o            ALU B select (1 = immediate)
//   wb_sel_o              write-back select (1 = memory data)
//   rf_we_o               register file write
//   pc_en_o               PC advance, once per retired instruction
//   busy_o, err_o         activity flag, sticky timeout flag
//   state_o [3]           encoded FSM state
//   instret_o [32]        retired-instruction counter
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int             OPW         = 4,
  parameter int             ACK_TIMEOUT = 16,
  parameter logic [OPW-1:0] LW_OP       = OPW'(8),
  parameter logic [OPW-1:0] SW_OP       = OPW'(9)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [OPW-1:0] opcode_i,
  input  logic           imem_ack_i,
  input  logic           dmem_ack_i,
  output logic           imem_req_o,
  output logic           ir_en_o,
  output logic           dmem_req_o,
  output logic           dmem_we_o,
  output logic           alub_sel_o,
  output logic           wb_sel_o,
  output logic           rf_we_o,
  output logic           pc_en_o,
  output logic           busy_o,
  output logic           err_o,
  output logic [2:0]     state_o,
  output logic [31:0]    instret_o
);

  localparam int             CW      = $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0]  CNT_MAX = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERROR  = 3'd6
  } state_e;

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0]    instret_q;

  // Registered strobes, computed from the next state so they line up with it.
  logic imem_req_q, dmem_req_q, dmem_we_q, alub_sel_q, wb_sel_q;
  logic rf_we_q, pc_wb_q, busy_q, err_q;

  logic is_mem_q, is_mem_d;
  logic imem_done, dmem_done, sw_retire;

  assign is_mem_q  = (op_q == LW_OP) || (op_q == SW_OP);
  assign is_mem_d  = (op_d == LW_OP) || (op_d == SW_OP);
  assign imem_done = (state_q == S_FETCH) && imem_ack_i;
  assign dmem_done = (state_q == S_MEM) && dmem_ack_i;
  assign sw_retire = dmem_done && (op_q == SW_OP);

  // Next-state, opcode capture and wait counter.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wait_cnt_d = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        // An ack in the final allowed cycle takes priority over the timeout.
        if (imem_ack_i)                state_d = S_DECODE;
        else if (wait_cnt_q == CNT_MAX) state_d = S_ERROR;
        else                           wait_cnt_d = wait_cnt_q + CW'(1);
      end
      S_DECODE: begin
        op_d    = opcode_i;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = is_mem_q ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (dmem_ack_i) begin
          if (op_q == SW_OP) state_d = start_i ? S_FETCH : S_IDLE;
          else               state_d = S_WB;
        end else if (wait_cnt_q == CNT_MAX) begin
          state_d = S_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      S_WB: begin
        state_d = start_i ? S_FETCH : S_IDLE;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      wait_cnt_q <= '0;
      instret_q  <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      alub_sel_q <= 1'b0;
      wb_sel_q   <= 1'b0;
      rf_we_q    <= 1'b0;
      pc_wb_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wait_cnt_q <= wait_cnt_d;
      if (pc_en_o) instret_q <= instret_q + 32'd1;
      imem_req_q <= (state_d == S_FETCH);
      dmem_req_q <= (state_d == S_MEM);
      dmem_we_q  <= (state_d == S_MEM) && (op_d == SW_OP);
      // Immediate stays selected through MEM so the address is stable.
      alub_sel_q <= ((state_d == S_EXEC) && is_mem_d) || (state_d == S_MEM);
      wb_sel_q   <= (state_d == S_WB) && (op_d == LW_OP);
      rf_we_q    <= (state_d == S_WB);
      pc_wb_q    <= (state_d == S_WB);
      busy_q     <= (state_d != S_IDLE) && (state_d != S_ERROR);
      err_q      <= (state_d == S_ERROR);
    end
  end

  // ir_en_o and the store-retire PC strobe follow the ack in the same cycle.
  assign imem_req_o = imem_req_q;
  assign ir_en_o    = imem_done;
  assign dmem_req_o = dmem_req_q;
  assign dmem_we_o  = dmem_we_q;
  assign alub_sel_o = alub_sel_q;
  assign wb_sel_o   = wb_sel_q;
  assign rf_we_o    = rf_we_q;
  assign pc_en_o    = pc_wb_q || sw_retire;
  assign busy_o     = busy_q;
  assign err_o      = err_q;
  assign state_o    = state_q;
  assign instret_o  = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Self-checking bench for multicycle_ctrl. Each cycle is described by a
// record of inputs and expected outputs. Records come from a directed table
// and from an instruction-level model that expands instructions (kind, fetch
// wait, memory wait, continue flag) into the cycle trace they must produce.
// Strobe bit order: [9]imem_req [8]ir_en [7]dmem_req [6]dmem_we [5]alub_sel
//                   [4]wb_sel [3]rf_we [2]pc_en [1]busy [0]err
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam logic [3:0] ADD = 4'h1;
  localparam logic [3:0] LW  = 4'h8;
  localparam logic [3:0] SW  = 4'h9;
  localparam int         TMO = 4;

  typedef struct packed {
    logic        start;
    logic [3:0]  op;
    logic        ia;
    logic        da;
    logic [2:0]  st;
    logic [9:0]  sb;
    logic [31:0] ir;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_i = 1'b0;
  logic [3:0]  opcode_i = '0;
  logic        imem_ack_i = 1'b0, dmem_ack_i = 1'b0;
  logic        imem_req_o, ir_en_o, dmem_req_o, dmem_we_o, alub_sel_o;
  logic        wb_sel_o, rf_we_o, pc_en_o, busy_o, err_o;
  logic [2:0]  state_o;
  logic [31:0] instret_o;

  multicycle_ctrl #(.OPW(4), .ACK_TIMEOUT(TMO), .LW_OP(LW), .SW_OP(SW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .opcode_i(opcode_i),
    .imem_ack_i(imem_ack_i), .dmem_ack_i(dmem_ack_i),
    .imem_req_o(imem_req_o), .ir_en_o(ir_en_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .alub_sel_o(alub_sel_o), .wb_sel_o(wb_sel_o),
    .rf_we_o(rf_we_o), .pc_en_o(pc_en_o), .busy_o(busy_o), .err_o(err_o),
    .state_o(state_o), .instret_o(instret_o)
  );

  // ---------------- scoreboard ----------------
  vec_t        exp_q[$];
  vec_t        tbl[9];
  int          errors = 0;
  int          checks = 0;
  int          step   = 0;
  logic [31:0] m_instret = '0;

  function automatic logic [12:0] got_ctl();
    return {state_o, imem_req_o, ir_en_o, dmem_req_o, dmem_we_o, alub_sel_o,
            wb_sel_o, rf_we_o, pc_en_o, busy_o, err_o};
  endfunction

  task automatic check_ctl(input string name, input logic [12:0] exp);
    checks++;
    if (got_ctl() !== exp) begin
      errors++;
      $display("FAIL %s step=%0d: state/strobes got=%b required=%b", name, step, got_ctl(), exp);
    end
  endtask

  task automatic check_ir(input string name, input logic [31:0] exp);
    checks++;
    if (instret_o !== exp) begin
      errors++;
      $display("FAIL %s step=%0d: instret got=%h required=%h", name, step, instret_o, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic apply_vec(input vec_t v, input string name);
    @(negedge clk);
    start_i    = v.start;
    opcode_i   = v.op;
    imem_ack_i = v.ia;
    dmem_ack_i = v.da;
    #1;
    check_ctl(name, {v.st, v.sb});
    check_ir(name, v.ir);
    step++;
  endtask

  task automatic run_q(input string name);
    while (exp_q.size() > 0) apply_vec(exp_q.pop_front(), name);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_ctl(name, 13'd0);
    check_ir(name, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start_i = 1'b0; imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
    m_instret = '0;
  endtask

  // ---------------- instruction-level model ----------------
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] ro();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic push(input logic s, input logic [3:0] op, input logic ia,
                      input logic da, input logic [2:0] st, input logic [9:0] sb);
    vec_t v;
    v.start = s; v.op = op; v.ia = ia; v.da = da; v.st = st; v.sb = sb;
    v.ir = m_instret;
    exp_q.push_back(v);
  endtask

  // n idle cycles with stray acks; the last one raises start when go is set
  task automatic add_idle(input int n, input logic go);
    for (int k = 0; k < n; k++)
      push((k == n - 1) ? go : 1'b0, ro(), rb(), rb(), 3'd0, 10'd0);
  endtask

  // FETCH with df wait cycles, then DECODE and EXEC
  task automatic add_front(input logic [3:0] op, input int df);
    logic mem;
    mem = (op == LW) || (op == SW);
    for (int k = 0; k <= df; k++)
      push(rb(), ro(), (k == df), rb(), 3'd1, (k == df) ? 10'b1100000010 : 10'b1000000010);
    push(rb(), op, rb(), rb(), 3'd2, 10'b0000000010);
    push(rb(), ro(), rb(), rb(), 3'd3, {4'b0000, mem, 5'b00010});
  endtask

  // n MEM cycles with no data ack
  task automatic add_mem_wait(input logic [3:0] op, input int n);
    for (int k = 0; k < n; k++)
      push(rb(), ro(), rb(), 1'b0, 3'd4, {3'b001, (op == SW), 6'b100010});
  endtask

  // MEM with dm wait cycles (memory ops), then WB; sa is start at retire
  task automatic add_tail(input logic [3:0] op, input int dm, input logic sa);
    if (op == LW || op == SW) begin
      add_mem_wait(op, dm);
      if (op == SW) begin
        push(sa, ro(), rb(), 1'b1, 3'd4, 10'b0011100110);
        m_instret++;
        return;
      end
      push(rb(), ro(), rb(), 1'b1, 3'd4, 10'b0010100010);
    end
    push(sa, ro(), rb(), rb(), 3'd5, {5'b00000, (op == LW), 4'b1110});
    m_instret++;
  endtask

  task automatic add_instr(input logic [3:0] op, input int df, input int dm, input logic sa);
    add_front(op, df);
    add_tail(op, dm, sa);
  endtask

  function automatic vec_t mkv(input logic s, input logic [3:0] op, input logic ia,
                               input logic da, input logic [2:0] st,
                               input logic [9:0] sb, input logic [31:0] ir);
    vec_t v;
    v.start = s; v.op = op; v.ia = ia; v.da = da; v.st = st; v.sb = sb; v.ir = ir;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    // ALU zero-wait, two instructions back to back with acks held high
    tbl[0] = mkv(1'b1, ADD, 1'b1, 1'b1, 3'd0, 10'b0000000000, 32'd0);
    tbl[1] = mkv(1'b1, ADD, 1'b1, 1'b1, 3'd1, 10'b1100000010, 32'd0);
    tbl[2] = mkv(1'b1, ADD, 1'b1, 1'b1, 3'd2, 10'b0000000010, 32'd0);
    tbl[3] = mkv(1'b1, ADD, 1'b1, 1'b1, 3'd3, 10'b0000000010, 32'd0);
    tbl[4] = mkv(1'b1, ADD, 1'b1, 1'b1, 3'd5, 10'b0000001110, 32'd0);
    tbl[5] = mkv(1'b1, ADD, 1'b1, 1'b1, 3'd1, 10'b1100000010, 32'd1);
    tbl[6] = mkv(1'b1, ADD, 1'b1, 1'b1, 3'd2, 10'b0000000010, 32'd1);
    tbl[7] = mkv(1'b1, ADD, 1'b1, 1'b1, 3'd3, 10'b0000000010, 32'd1);
    tbl[8] = mkv(1'b0, ADD, 1'b1, 1'b1, 3'd5, 10'b0000001110, 32'd1);

    // power-on reset
    #1;
    check_ctl("reset_por", 13'd0);
    check_ir("reset_por", 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) apply_vec(tbl[i], "alu_zero_wait");
    m_instret = 32'd2;

    // LW with dmem ack on the 4th MEM cycle, then stop
    add_idle(2, 1'b1);
    add_instr(LW, 0, 3, 1'b0);
    // SW retiring straight into the next FETCH
    add_idle(1, 1'b1);
    add_instr(SW, 0, 1, 1'b1);
    add_instr(ADD, 1, 0, 1'b0);
    // fetch ack in the last allowed cycle wins over the timeout
    add_idle(1, 1'b1);
    add_instr(ADD, TMO - 1, 0, 1'b0);
    // store and load acks in their last allowed cycle
    add_idle(1, 1'b1);
    add_instr(SW, 1, TMO - 1, 1'b1);
    add_instr(LW, 0, TMO - 1, 1'b0);
    add_idle(3, 1'b0);
    run_q("directed");

    // reset during MEM with the request up
    add_idle(1, 1'b1);
    add_front(LW, 0);
    add_mem_wait(LW, 2);
    run_q("pre_reset");
    do_reset("reset_mid_mem");
    add_idle(1, 1'b1);
    add_instr(ADD, 0, 0, 1'b0);
    add_idle(1, 1'b0);
    run_q("post_reset");

    // fetch timeout: request held TMO cycles, then sticky ERROR
    add_idle(1, 1'b1);
    for (int k = 0; k < TMO; k++) push(rb(), ro(), 1'b0, rb(), 3'd1, 10'b1000000010);
    for (int k = 0; k < 4; k++)   push(rb(), ro(), rb(), rb(), 3'd6, 10'b0000000001);
    run_q("fetch_timeout");
    do_reset("reset_from_error");

    // data timeout on a store
    add_idle(1, 1'b1);
    add_front(SW, 0);
    add_mem_wait(SW, TMO);
    for (int k = 0; k < 3; k++) push(rb(), ro(), rb(), rb(), 3'd6, 10'b0000000001);
    run_q("mem_timeout");
    do_reset("reset_from_error2");

    // counter wrap
    @(negedge clk);
    force dut.instret_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.instret_q;
    m_instret = 32'hFFFF_FFFF;
    add_idle(1, 1'b1);
    add_instr(ADD, 0, 0, 1'b0);
    add_idle(1, 1'b0);
    run_q("instret_wrap");
    do_reset("reset_after_wrap");

    // randomized instruction stream
    add_idle(1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      logic       sa;
      int         kind;
      kind = $urandom_range(0, 2);
      op   = (kind == 0) ? LW : (kind == 1) ? SW : 4'($urandom_range(0, 7));
      sa   = (i == 39) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
      add_instr(op, $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1), sa);
      if (!sa) add_idle($urandom_range(1, 3), (i != 39));
    end
    run_q("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
